switch_debounce: RTL and testbench

- Upstream conditioning stage for the three-switch lamp controller (S1/S2/S3 -> decoder -> lamp F / Buzzer).
- Synchronises raw mechanical switch levels to the system clock and debounces each one with a per-channel stability counter.
- Outputs clean levels for the lamp logic, plus one-cycle change pulses for event-driven consumers such as a buzzer chirp.

---
 rtl/switch_debounce.sv | 125 ++++++++++++
 tb/tb_switch_debounce.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-flop synchroniser plus per-channel debounce FSM for N switches.
// Define SW_TOGGLE_EN to make sw_db a per-channel toggle that flips on each debounced press.
module switch_debounce #(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_db,
  output logic [N-1:0] sw_chg,
  output logic         any_chg
);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [N-1:0]     lvl;
  logic [N-1:0]     mism;
  logic [N-1:0]     flip;
  logic [N-1:0]     chg_d;
  state_t           state_q [N];
  state_t           state_d [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [CNT_W-1:0] cnt_d   [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  assign mism = sync2 ^ lvl;

  // The counter is cleared on every flip and bounce-back, so it never wraps.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      flip[i]    = 1'b0;
      case (state_q[i])
        STABLE: begin
          cnt_d[i] = '0;
          if (mism[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              flip[i] = 1'b1;
            end else begin
              state_d[i] = COUNTING;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        COUNTING: begin
          if (!mism[i]) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            flip[i]    = 1'b1;
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
      lvl     <= '0;
      sw_chg  <= '0;
      any_chg <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      lvl     <= lvl ^ flip;
      sw_chg  <= chg_d;
      any_chg <= |chg_d;
    end
  end

`ifdef SW_TOGGLE_EN
  logic [N-1:0] tog;

  // Only debounced rising edges (level currently 0 and flipping) toggle the output.
  assign chg_d = flip & ~lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog <= '0;
    end else begin
      tog <= tog ^ chg_d;
    end
  end

  assign sw_db = tog;
`else
  assign chg_d = flip;
  assign sw_db = lvl;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - directed self-checking bench for switch_debounce (DEBOUNCE_CYCLES=4).
module tb_switch_debounce;

  logic       clk;
  logic       rst_n;
  logic [2:0] sw_raw;
  logic [2:0] sw_db;
  logic [2:0] sw_chg;
  logic       any_chg;

  int checks = 0;
  int errors = 0;

  switch_debounce dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_db   (sw_db),
    .sw_chg  (sw_chg),
    .any_chg (any_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then sample at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sw_raw = 3'b111;
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++;
      if ({sw_db, sw_chg, any_chg} !== 7'b0) begin
        errors++;
        $display("FAIL reset_hold c=%0d db=%b chg=%b any=%b expected all zero", c, sw_db, sw_chg, any_chg);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      logic [2:0] e_db, e_chg;
      step();
      e_db  = (c >= 6) ? 3'b111 : 3'b000;
      e_chg = (c == 6) ? 3'b111 : 3'b000;
      checks++;
      if ({sw_db, sw_chg, any_chg} !== {e_db, e_chg, |e_chg}) begin
        errors++;
        $display("FAIL reset_release c=%0d db=%b chg=%b any=%b expected db=%b chg=%b any=%b",
                 c, sw_db, sw_chg, any_chg, e_db, e_chg, |e_chg);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_db, sw_chg, any_chg} !== 7'b0) begin
      errors++;
      $display("FAIL reset_async db=%b chg=%b any=%b expected all zero", sw_db, sw_chg, any_chg);
    end
    sw_raw = 3'b000;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_clean_step();
    logic [2:0] from_v, to_v;
    for (int dir = 0; dir < 2; dir++) begin
      from_v = (dir == 0) ? 3'b000 : 3'b001;
      to_v   = (dir == 0) ? 3'b001 : 3'b000;
      sw_raw = to_v;
      for (int c = 1; c <= 9; c++) begin
        logic [2:0] e_db, e_chg;
        step();
        e_db  = (c >= 6) ? to_v : from_v;
        e_chg = (c == 6) ? 3'b001 : 3'b000;
        checks++;
        if ({sw_db, sw_chg, any_chg} !== {e_db, e_chg, |e_chg}) begin
          errors++;
          $display("FAIL clean_step dir=%0d c=%0d db=%b chg=%b any=%b expected db=%b chg=%b any=%b",
                   dir, c, sw_db, sw_chg, any_chg, e_db, e_chg, |e_chg);
        end
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 1; c <= 38; c++) begin
      sw_raw = (c <= 18 && ((c - 1) % 6) < 3) ? 3'b010 : 3'b000;
      step();
      checks++;
      if ({sw_db, sw_chg, any_chg} !== 7'b0) begin
        errors++;
        $display("FAIL bounce c=%0d db=%b chg=%b any=%b expected all zero", c, sw_db, sw_chg, any_chg);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] from_v, to_v;
    for (int dir = 0; dir < 2; dir++) begin
      from_v = (dir == 0) ? 3'b000 : 3'b101;
      to_v   = (dir == 0) ? 3'b101 : 3'b000;
      sw_raw = to_v;
      for (int c = 1; c <= 9; c++) begin
        logic [2:0] e_db, e_chg;
        step();
        e_db  = (c >= 6) ? to_v : from_v;
        e_chg = (c == 6) ? 3'b101 : 3'b000;
        checks++;
        if ({sw_db, sw_chg, any_chg} !== {e_db, e_chg, |e_chg}) begin
          errors++;
          $display("FAIL simultaneous dir=%0d c=%0d db=%b chg=%b any=%b expected db=%b chg=%b any=%b",
                   dir, c, sw_db, sw_chg, any_chg, e_db, e_chg, |e_chg);
        end
      end
    end
  endtask

  task automatic test_reset_mid_count();
    sw_raw = 3'b100;
    for (int c = 1; c <= 4; c++) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sw_db, sw_chg, any_chg} !== 7'b0) begin
      errors++;
      $display("FAIL mid_count_assert db=%b chg=%b any=%b expected all zero", sw_db, sw_chg, any_chg);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if ({sw_db, sw_chg, any_chg} !== 7'b0) begin
        errors++;
        $display("FAIL mid_count_hold c=%0d db=%b chg=%b any=%b expected all zero", c, sw_db, sw_chg, any_chg);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      logic [2:0] e_db, e_chg;
      step();
      e_db  = (c >= 6) ? 3'b100 : 3'b000;
      e_chg = (c == 6) ? 3'b100 : 3'b000;
      checks++;
      if ({sw_db, sw_chg, any_chg} !== {e_db, e_chg, |e_chg}) begin
        errors++;
        $display("FAIL mid_count_release c=%0d db=%b chg=%b any=%b expected db=%b chg=%b any=%b",
                 c, sw_db, sw_chg, any_chg, e_db, e_chg, |e_chg);
      end
    end
    sw_raw = 3'b000;
    for (int c = 1; c <= 8; c++) step();
    checks++;
    if ({sw_db, sw_chg, any_chg} !== 7'b0) begin
      errors++;
      $display("FAIL mid_count_clear db=%b chg=%b any=%b expected all zero", sw_db, sw_chg, any_chg);
    end
  endtask

  task automatic test_toggle();
    logic [2:0] e_db;
    int         pulses;
    e_db   = 3'b000;
    pulses = 0;
    rst_n  = 1'b0;
    sw_raw = 3'b000;
    step();
    rst_n = 1'b1;
    step();
    for (int p = 0; p < 2; p++) begin
      for (int c = 1; c <= 20; c++) begin
        logic [2:0] e_chg;
        sw_raw = (c <= 10) ? 3'b001 : 3'b000;
        step();
        e_chg = (c == 6) ? 3'b001 : 3'b000;
        if (c == 6) e_db = e_db ^ 3'b001;
        if (sw_chg[0]) pulses++;
        checks++;
        if ({sw_db, sw_chg, any_chg} !== {e_db, e_chg, |e_chg}) begin
          errors++;
          $display("FAIL toggle p=%0d c=%0d db=%b chg=%b any=%b expected db=%b chg=%b any=%b",
                   p, c, sw_db, sw_chg, any_chg, e_db, e_chg, |e_chg);
        end
      end
    end
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL toggle_pulses got=%0d expected=2", pulses);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_raw = 3'b000;
`ifdef SW_TOGGLE_EN
    test_toggle();
`else
    test_reset();
    test_clean_step();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
